// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter_if
//  Description : Bundles the two requester ports (A = image_processing core,
//                B = host/SPI loader) and the shared ram_interface port of
//                ram_arbiter.
//                slave  modport : the arbiter itself
//                master modport : the surrounding requesters and RAM side
//  Ports       : a_* / b_*  : command (addr, wr_en, rd_en, data_write),
//                             ack, read data and read-data valid per requester
//                mem_*      : addr, wr_en, rd_en, data_write to the RAM,
//                             data_read, data_read_valid from the RAM
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    // Requester A
    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_wr_en;
    logic                  a_rd_en;
    logic [DATA_WIDTH-1:0] a_data_write;
    logic                  a_ack;
    logic [DATA_WIDTH-1:0] a_data_read;
    logic                  a_data_read_valid;

    // Requester B
    logic [ADDR_WIDTH-1:0] b_addr;
    logic                  b_wr_en;
    logic                  b_rd_en;
    logic [DATA_WIDTH-1:0] b_data_write;
    logic                  b_ack;
    logic [DATA_WIDTH-1:0] b_data_read;
    logic                  b_data_read_valid;

    // Shared RAM port
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_data_write;
    logic [DATA_WIDTH-1:0] mem_data_read;
    logic                  mem_data_read_valid;

    modport slave (
        input  a_addr, a_wr_en, a_rd_en, a_data_write,
        output a_ack, a_data_read, a_data_read_valid,
        input  b_addr, b_wr_en, b_rd_en, b_data_write,
        output b_ack, b_data_read, b_data_read_valid,
        output mem_addr, mem_wr_en, mem_rd_en, mem_data_write,
        input  mem_data_read, mem_data_read_valid
    );

    modport master (
        output a_addr, a_wr_en, a_rd_en, a_data_write,
        input  a_ack, a_data_read, a_data_read_valid,
        output b_addr, b_wr_en, b_rd_en, b_data_write,
        input  b_ack, b_data_read, b_data_read_valid,
        input  mem_addr, mem_wr_en, mem_rd_en, mem_data_write,
        output mem_data_read, mem_data_read_valid
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares one 16-bit ram_interface port between requester A
//                (image_processing core) and requester B (host/SPI loader).
//                Round-robin grant of read/write commands, registered issue
//                onto the RAM port, and in-order routing of read responses
//                back to the requester that issued each read.
//  Ports       : clk       - system clock
//                reset     - asynchronous active-low reset
//                bus       - ram_arbiter_if.slave (requester A/B + RAM port)
//                rsp_error - sticky: a read response arrived with no read
//                            outstanding
//  Options     : RAM_ARBITER_PRIORITY_A_EN - when defined, A always wins a
//                contention (fixed priority); otherwise round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4     // power of two, >= 2
) (
    input  wire logic    clk,
    input  wire logic    reset,
    ram_arbiter_if.slave bus,
    output logic         rsp_error
);

    localparam int c_ptr_w = $clog2(MAX_OUTSTANDING);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [c_cnt_w-1:0] c_one_cnt = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_one_ptr = c_ptr_w'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]      mem_addr_q,       mem_addr_d;
    logic                       mem_wr_en_q,      mem_wr_en_d;
    logic                       mem_rd_en_q,      mem_rd_en_d;
    logic [DATA_WIDTH-1:0]      mem_data_write_q, mem_data_write_d;

    // Owner FIFO: one bit per outstanding read, 0 = A, 1 = B
    logic [MAX_OUTSTANDING-1:0] owner_q,  owner_d;
    logic [c_ptr_w-1:0]         wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]         rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]         cnt_q,    cnt_d;

    logic [DATA_WIDTH-1:0]      data_read_q, data_read_d;
    logic                       a_valid_q,   a_valid_d;
    logic                       b_valid_q,   b_valid_d;
    logic                       rsp_error_q, rsp_error_d;

    // ------------------------------------------------------------------
    // Request decode and eligibility
    // ------------------------------------------------------------------
    logic w_rd_room;
    logic w_a_rd_cmd, w_b_rd_cmd;
    logic w_a_elig,   w_b_elig;
    logic w_grant_a,  w_grant_b;
    logic w_push,     w_pop, w_stray, w_head_owner;

    // A simultaneous wr_en/rd_en is a write; the read half is dropped
    assign w_a_rd_cmd = bus.a_rd_en & ~bus.a_wr_en;
    assign w_b_rd_cmd = bus.b_rd_en & ~bus.b_wr_en;

    // Reads need a free owner-FIFO slot; writes never wait on reads
    assign w_rd_room  = (cnt_q < c_max_cnt);
    assign w_a_elig   = bus.a_wr_en | (w_a_rd_cmd & w_rd_room);
    assign w_b_elig   = bus.b_wr_en | (w_b_rd_cmd & w_rd_room);

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
`ifdef RAM_ARBITER_PRIORITY_A_EN
    assign w_grant_a = w_a_elig;
    assign w_grant_b = w_b_elig & ~w_a_elig;
`else
    // last_grant_q: 0 = A granted last, 1 = B granted last.
    // Resets to B so that A wins the first contention.
    logic last_grant_q;

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (w_a_elig && w_b_elig) begin
            w_grant_a = last_grant_q;
            w_grant_b = ~last_grant_q;
        end else begin
            w_grant_a = w_a_elig;
            w_grant_b = w_b_elig;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else if (w_grant_a || w_grant_b) begin
            last_grant_q <= w_grant_b;
        end
    end
`endif

    assign bus.a_ack = w_grant_a;
    assign bus.b_ack = w_grant_b;

    // ------------------------------------------------------------------
    // Read tracking
    // ------------------------------------------------------------------
    // The owner is recorded at the grant edge, the same edge that raises
    // mem_rd_en, so the count is already current for the next cycle.
    assign w_push       = (w_grant_a & w_a_rd_cmd) | (w_grant_b & w_b_rd_cmd);
    assign w_pop        = bus.mem_data_read_valid & (cnt_q != '0);
    assign w_stray      = bus.mem_data_read_valid & (cnt_q == '0);
    assign w_head_owner = owner_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr_d       = mem_addr_q;
        mem_data_write_d = mem_data_write_q;
        mem_wr_en_d      = 1'b0;
        mem_rd_en_d      = 1'b0;
        owner_d          = owner_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        cnt_d            = cnt_q;
        data_read_d      = data_read_q;
        a_valid_d        = 1'b0;
        b_valid_d        = 1'b0;
        rsp_error_d      = rsp_error_q | w_stray;

        // Issue: strobes last one cycle, addr/data hold between grants
        if (w_grant_a) begin
            mem_addr_d       = bus.a_addr;
            mem_data_write_d = bus.a_data_write;
            mem_wr_en_d      = bus.a_wr_en;
            mem_rd_en_d      = w_a_rd_cmd;
        end else if (w_grant_b) begin
            mem_addr_d       = bus.b_addr;
            mem_data_write_d = bus.b_data_write;
            mem_wr_en_d      = bus.b_wr_en;
            mem_rd_en_d      = w_b_rd_cmd;
        end

        if (w_push) begin
            owner_d[wr_ptr_q] = w_grant_b;
            wr_ptr_d          = wr_ptr_q + c_one_ptr;
        end

        if (w_pop) begin
            rd_ptr_d    = rd_ptr_q + c_one_ptr;
            data_read_d = bus.mem_data_read;
            a_valid_d   = ~w_head_owner;
            b_valid_d   = w_head_owner;
        end

        unique case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + c_one_cnt;
            2'b01:   cnt_d = cnt_q - c_one_cnt;
            default: cnt_d = cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr_q       <= '0;
            mem_wr_en_q      <= 1'b0;
            mem_rd_en_q      <= 1'b0;
            mem_data_write_q <= '0;
            owner_q          <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            cnt_q            <= '0;
            data_read_q      <= '0;
            a_valid_q        <= 1'b0;
            b_valid_q        <= 1'b0;
            rsp_error_q      <= 1'b0;
        end else begin
            mem_addr_q       <= mem_addr_d;
            mem_wr_en_q      <= mem_wr_en_d;
            mem_rd_en_q      <= mem_rd_en_d;
            mem_data_write_q <= mem_data_write_d;
            owner_q          <= owner_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            cnt_q            <= cnt_d;
            data_read_q      <= data_read_d;
            a_valid_q        <= a_valid_d;
            b_valid_q        <= b_valid_d;
            rsp_error_q      <= rsp_error_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_addr          = mem_addr_q;
    assign bus.mem_wr_en         = mem_wr_en_q;
    assign bus.mem_rd_en         = mem_rd_en_q;
    assign bus.mem_data_write    = mem_data_write_q;
    assign bus.a_data_read       = data_read_q;
    assign bus.b_data_read       = data_read_q;
    assign bus.a_data_read_valid = a_valid_q;
    assign bus.b_data_read_valid = b_valid_q;
    assign rsp_error             = rsp_error_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Self-checking bench for ram_arbiter. Directed stimulus pushes
//                expected RAM commands and read responses into queues; a
//                monitor pops and compares whenever the DUT presents a strobe
//                or a read-data valid.
//  Options     : RAM_ARBITER_PRIORITY_A_EN selects fixed-priority expectations
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int c_aw = 32;
    localparam int c_dw = 16;

    typedef struct packed {
        logic            wr;
        logic            rd;
        logic [c_aw-1:0] addr;
        logic [c_dw-1:0] data;
    } cmd_t;

    logic clk;
    logic reset;
    logic rsp_error;

    ram_arbiter_if #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw)) bus ();

    ram_arbiter #(
        .ADDR_WIDTH     (c_aw),
        .DATA_WIDTH     (c_dw),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .rsp_error(rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    cmd_t            exp_cmd[$];
    logic [c_dw-1:0] exp_a[$];
    logic [c_dw-1:0] exp_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    cmd_t            mon_e;
    logic [c_dw-1:0] mon_d;

    always @(negedge clk) begin
        if (reset) begin
            check("single_ack", {63'd0, bus.a_ack & bus.b_ack}, 64'd0);
            if (bus.mem_wr_en || bus.mem_rd_en) begin
                if (exp_cmd.size() == 0) begin
                    check("unexpected_mem_cmd", {62'd0, bus.mem_wr_en, bus.mem_rd_en}, 64'd0);
                end else begin
                    mon_e = exp_cmd.pop_front();
                    check("mem_wr_en", {63'd0, bus.mem_wr_en}, {63'd0, mon_e.wr});
                    check("mem_rd_en", {63'd0, bus.mem_rd_en}, {63'd0, mon_e.rd});
                    check("mem_addr",  {32'd0, bus.mem_addr},  {32'd0, mon_e.addr});
                    if (mon_e.wr)
                        check("mem_data_write", {48'd0, bus.mem_data_write}, {48'd0, mon_e.data});
                end
            end
            if (bus.a_data_read_valid) begin
                if (exp_a.size() == 0) begin
                    check("unexpected_a_valid", {63'd0, bus.a_data_read_valid}, 64'd0);
                end else begin
                    mon_d = exp_a.pop_front();
                    check("a_data_read", {48'd0, bus.a_data_read}, {48'd0, mon_d});
                end
            end
            if (bus.b_data_read_valid) begin
                if (exp_b.size() == 0) begin
                    check("unexpected_b_valid", {63'd0, bus.b_data_read_valid}, 64'd0);
                end else begin
                    mon_d = exp_b.pop_front();
                    check("b_data_read", {48'd0, bus.b_data_read}, {48'd0, mon_d});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        bus.a_addr = '0; bus.a_wr_en = 1'b0; bus.a_rd_en = 1'b0; bus.a_data_write = '0;
        bus.b_addr = '0; bus.b_wr_en = 1'b0; bus.b_rd_en = 1'b0; bus.b_data_write = '0;
        bus.mem_data_read = '0; bus.mem_data_read_valid = 1'b0;
    endtask

    // Inputs are already set for this cycle; check acks mid-cycle, then
    // advance to just after the next rising edge.
    task automatic step_ack(input string name, input logic ea, input logic eb);
        @(negedge clk);
        check({name, "_a_ack"}, {63'd0, bus.a_ack}, {63'd0, ea});
        check({name, "_b_ack"}, {63'd0, bus.b_ack}, {63'd0, eb});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_ack("idle", 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        check("rst_mem_strobes", {62'd0, bus.mem_wr_en, bus.mem_rd_en}, 64'd0);
        check("rst_valids", {62'd0, bus.a_data_read_valid, bus.b_data_read_valid}, 64'd0);
        check("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic push_cmd(input logic wr, input logic rd, input logic [c_aw-1:0] addr,
                            input logic [c_dw-1:0] data);
        cmd_t c;
        c.wr = wr; c.rd = rd; c.addr = addr; c.data = data;
        exp_cmd.push_back(c);
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b0;
        clear_inputs();

        // Reset state
        @(negedge clk);
        check("reset_mem_addr",  {32'd0, bus.mem_addr}, 64'd0);
        check("reset_mem_data",  {48'd0, bus.mem_data_write}, 64'd0);
        check("reset_strobes",   {62'd0, bus.mem_wr_en, bus.mem_rd_en}, 64'd0);
        check("reset_data_read", {32'd0, bus.a_data_read, bus.b_data_read}, 64'd0);
        check("reset_valids",    {62'd0, bus.a_data_read_valid, bus.b_data_read_valid}, 64'd0);
        check("reset_rsp_error", {63'd0, rsp_error}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: single write from A, B idle
        bus.a_wr_en = 1'b1; bus.a_addr = 32'h10; bus.a_data_write = 16'hBEEF;
        push_cmd(1'b1, 1'b0, 32'h10, 16'hBEEF);
        step_ack("single_wr", 1'b1, 1'b0);
        bus.a_wr_en = 1'b0;
        idle(2);

        // 2: contention, both write for 6 cycles
        do_reset();
        begin
            int ai = 0;
            int bi = 0;
            logic ea;
            bus.a_wr_en = 1'b1;
            bus.b_wr_en = 1'b1;
            for (int i = 0; i < 6; i++) begin
                bus.a_addr = 32'h100 + 32'(ai); bus.a_data_write = 16'hA000 + 16'(ai);
                bus.b_addr = 32'h200 + 32'(bi); bus.b_data_write = 16'hB000 + 16'(bi);
`ifdef RAM_ARBITER_PRIORITY_A_EN
                ea = 1'b1;
`else
                ea = ((i % 2) == 0);
`endif
                if (ea) begin
                    push_cmd(1'b1, 1'b0, 32'h100 + 32'(ai), 16'hA000 + 16'(ai));
                    ai++;
                end else begin
                    push_cmd(1'b1, 1'b0, 32'h200 + 32'(bi), 16'hB000 + 16'(bi));
                    bi++;
                end
                step_ack("contend", ea, ~ea);
            end
            bus.a_wr_en = 1'b0;
            bus.b_wr_en = 1'b0;
        end
        idle(2);

        // 3: read routing, 3-cycle RAM latency
        do_reset();
        bus.a_rd_en = 1'b1; bus.a_addr = 32'h20;
        push_cmd(1'b0, 1'b1, 32'h20, 16'h0);
        step_ack("rd_a", 1'b1, 1'b0);
        bus.a_rd_en = 1'b0;
        bus.b_rd_en = 1'b1; bus.b_addr = 32'h21;
        push_cmd(1'b0, 1'b1, 32'h21, 16'h0);
        step_ack("rd_b", 1'b0, 1'b1);
        bus.b_rd_en = 1'b0;
        idle(2);
        bus.mem_data_read_valid = 1'b1; bus.mem_data_read = 16'h1111;
        exp_a.push_back(16'h1111);
        step_ack("rsp_a", 1'b0, 1'b0);
        bus.mem_data_read = 16'h2222;
        exp_b.push_back(16'h2222);
        step_ack("rsp_b", 1'b0, 1'b0);
        bus.mem_data_read_valid = 1'b0;
        idle(3);

        // 4: outstanding limit
        do_reset();
        bus.a_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.a_addr = 32'h30 + 32'(i);
            push_cmd(1'b0, 1'b1, 32'h30 + 32'(i), 16'h0);
            step_ack("rd_fill", 1'b1, 1'b0);
        end
        bus.a_addr = 32'h34;
        bus.b_wr_en = 1'b1; bus.b_addr = 32'h40; bus.b_data_write = 16'h5555;
        push_cmd(1'b1, 1'b0, 32'h40, 16'h5555);
        step_ack("full", 1'b0, 1'b1);
        bus.b_wr_en = 1'b0;
        bus.mem_data_read_valid = 1'b1; bus.mem_data_read = 16'h0030;
        exp_a.push_back(16'h0030);
        step_ack("full_rsp", 1'b0, 1'b0);
        bus.mem_data_read_valid = 1'b0;
        push_cmd(1'b0, 1'b1, 32'h34, 16'h0);
        step_ack("after_pop", 1'b1, 1'b0);
        bus.a_rd_en = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            bus.mem_data_read_valid = 1'b1; bus.mem_data_read = 16'h0030 + 16'(j);
            exp_a.push_back(16'h0030 + 16'(j));
            step_ack("drain", 1'b0, 1'b0);
        end
        bus.mem_data_read_valid = 1'b0;
        idle(3);

        // 5: stray response with nothing outstanding
        do_reset();
        check("stray_pre_err", {63'd0, rsp_error}, 64'd0);
        bus.mem_data_read_valid = 1'b1; bus.mem_data_read = 16'hDEAD;
        step_ack("stray", 1'b0, 1'b0);
        bus.mem_data_read_valid = 1'b0;
        step_ack("stray_idle", 1'b0, 1'b0);
        check("stray_err_set", {63'd0, rsp_error}, 64'd1);
        idle(4);
        check("stray_err_sticky", {63'd0, rsp_error}, 64'd1);

        // 6: reset with two reads in flight
        do_reset();
        bus.a_rd_en = 1'b1; bus.a_addr = 32'h50;
        push_cmd(1'b0, 1'b1, 32'h50, 16'h0);
        step_ack("mf_rd0", 1'b1, 1'b0);
        bus.a_addr = 32'h51;
        push_cmd(1'b0, 1'b1, 32'h51, 16'h0);
        step_ack("mf_rd1", 1'b1, 1'b0);
        bus.a_rd_en = 1'b0;
        idle(1);
        do_reset();
        bus.mem_data_read_valid = 1'b1; bus.mem_data_read = 16'hAAAA;
        step_ack("late_rsp0", 1'b0, 1'b0);
        bus.mem_data_read = 16'hBBBB;
        step_ack("late_rsp1", 1'b0, 1'b0);
        bus.mem_data_read_valid = 1'b0;
        idle(2);
        check("midflight_err", {63'd0, rsp_error}, 64'd1);
        bus.a_wr_en = 1'b1; bus.a_addr = 32'h60; bus.a_data_write = 16'h1234;
        push_cmd(1'b1, 1'b0, 32'h60, 16'h1234);
        step_ack("post_rst_wr", 1'b1, 1'b0);
        bus.a_wr_en = 1'b0;
        idle(3);

        check("queues_empty", 64'(exp_cmd.size() + exp_a.size() + exp_b.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 16-bit ram_interface port between two requesters: port A (image_processing core) and port B (host/SPI loader path).
- Performs round-robin arbitration of read/write commands and registers the winner onto the RAM port.
- Tracks outstanding reads and routes each data_read_valid back to the requester that issued the read.

Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 16, data width on all ports
- MAX_OUTSTANDING, 4, maximum reads in flight; owner-FIFO depth, power of two, minimum 2

Ports:
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-low reset
- a_addr  in  ADDR_WIDTH  port A command address
- a_wr_en  in  1  port A write request
- a_rd_en  in  1  port A read request
- a_data_write  in  DATA_WIDTH  port A write data
- a_ack  out  1  port A command accepted this cycle (combinational)
- a_data_read  out  DATA_WIDTH  port A read data
- a_data_read_valid  out  1  port A read data valid
- b_addr, b_wr_en, b_rd_en, b_data_write, b_ack, b_data_read, b_data_read_valid: same as the port A signals, for port B
- mem_addr  out  ADDR_WIDTH  to ram_interface addr
- mem_wr_en  out  1  to ram_interface wr_en
- mem_rd_en  out  1  to ram_interface rd_en
- mem_data_write  out  DATA_WIDTH  to ram_interface data_write
- mem_data_read  in  DATA_WIDTH  from ram_interface data_read
- mem_data_read_valid  in  1  from ram_interface data_read_valid
- rsp_error  out  1  sticky flag: a read response arrived with no outstanding read

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All mem_* outputs, *_data_read, *_data_read_valid and rsp_error are 0.
  - Owner FIFO is empty; outstanding count is 0.
  - last_grant = B, so A wins the first contention.
- Request:
  - A port requests when its wr_en or rd_en is high.
  - Command fields must stay stable until *_ack is seen high.
  - If wr_en and rd_en are both high, the command is a write; the read is discarded.
- Eligibility: a read request is eligible only if outstanding < MAX_OUTSTANDING. Write requests are always eligible.
- Grant, combinational per cycle:
  - If only one port is eligible, grant it.
  - If both are eligible, grant the port other than last_grant.
  - At most one *_ack is high per cycle.
  - last_grant updates at the clock edge on any grant.
- Issue:
  - At the edge ending a grant cycle, mem_addr/mem_wr_en/mem_rd_en/mem_data_write register the granted command.
  - Strobes are high for exactly one cycle.
  - With no grant, strobes go to 0; addr and data hold their last values.
  - Latency from ack to mem strobe: 1 cycle.
  - Back-to-back grants allow one command per cycle.
- Read tracking:
  - On a read issue, push the owner ID (0 = A, 1 = B) into the owner FIFO.
  - On mem_data_read_valid, pop the FIFO head.
  - Push and pop in the same cycle leave the count unchanged.
  - The ram_interface returns reads in issue order.
- Response routing:
  - One cycle after mem_data_read_valid, mem_data_read is registered to both *_data_read.
  - Only the owner's *_data_read_valid pulses, for 1 cycle.
- Empty-FIFO response: if mem_data_read_valid arrives with outstanding = 0, the response is dropped, no valid pulses, and rsp_error sets. Only reset clears rsp_error.
- Reset mid-operation: in-flight reads are forgotten. Their late responses after reset are dropped and set rsp_error.
- Writes do not interact with the read order and are never blocked by outstanding reads.

Optional Feature:
- Macro: RAM_ARBITER_PRIORITY_A_EN.
- Defined: fixed priority. Port A always wins when both ports are eligible; last_grant is unused. B can starve while A requests continuously.
- Undefined: round-robin as described above.

Test Plan:
- Single write, B idle: A write, addr 0x10, data 0xBEEF → a_ack in cycle 0; mem_wr_en=1, mem_addr=0x10, mem_data_write=0xBEEF in cycle 1; b_ack never high.
- Contention: A and B both write continuously for 6 cycles → acks alternate A,B,A,B,A,B starting with A (macro undefined); with macro defined, a_ack high all 6 cycles.
- Read routing: A reads 0x20, then B reads 0x21; RAM returns 0x1111 then 0x2222 with 3-cycle latency → a_data_read_valid with 0x1111, then b_data_read_valid with 0x2222; no cross-delivery.
- Outstanding full: A issues 4 reads with RAM withholding responses; a 5th A read gets no ack while a B write is still acked; after one response the 5th read is acked the next cycle.
- Stray response: pulse mem_data_read_valid with 0xDEAD after reset, no reads issued → no *_data_read_valid; rsp_error=1 and stays 1 until reset.
- Reset mid-flight: 2 reads outstanding, assert reset for 1 cycle, RAM then returns 2 responses → no valids; rsp_error=1; the next A write is acked normally.
